// File: rtl/lsram_fifo_pkg.sv
// rtl/lsram_fifo_pkg.sv - shared types and sizing constants for the LSRAM FIFO controller
package lsram_fifo_pkg;

  localparam int FIFO_DATA_W = 32;
  localparam int FIFO_ADDR_W = 9;
  localparam int FIFO_DEPTH  = 512;

  typedef enum logic [1:0] {
    H_EMPTY = 2'd0,
    H_PEND  = 2'd1,
    H_HOLD  = 2'd2
  } head_state_e;

endpackage

// File: rtl/lsram_fifo_ctrl.sv
// rtl/lsram_fifo_ctrl.sv - FWFT FIFO controller for an external 512x32 two-port LSRAM
// Optional sticky OVERFLOW/UNDERFLOW status under macro LSRAM_FIFO_CTRL_STATUS_EN.
module lsram_fifo_ctrl
  import lsram_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WE,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              RE,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              EMPTY,
  output logic              FULL,
  output logic [ADDR_W:0]   COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
  output logic [DATA_W-1:0] RAM_W_DATA,
  output logic [ADDR_W-1:0] RAM_W_ADDR,
  output logic              RAM_W_EN,
  output logic [ADDR_W-1:0] RAM_R_ADDR,
  output logic              RAM_R_EN,
  input  logic [DATA_W-1:0] RAM_R_DATA
);

  localparam int            DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  head_state_e       state_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] out_reg_q;

  logic full, empty, push_ok, pop_ok, ram_avail, rd_issue;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (state_q == H_EMPTY);
  assign push_ok   = WE & ~full & ~RESET;
  assign pop_ok    = RE & ~empty & ~RESET;
  // Registered RAM occupancy only: a same-cycle push is never read back immediately.
  assign ram_avail = (ram_cnt_q != '0);

  always_comb begin
    rd_issue = 1'b0;
    if (!RESET) begin
      case (state_q)
        H_EMPTY: rd_issue = ram_avail;
        default: rd_issue = pop_ok & ram_avail;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + ADDR_W'(push_ok);
    rd_ptr_d  = rd_ptr_q + ADDR_W'(rd_issue);
    ram_cnt_d = ram_cnt_q;
    case ({push_ok, rd_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= H_EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      count_q   <= '0;
      out_reg_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      count_q   <= count_d;
      case (state_q)
        H_EMPTY: begin
          if (ram_avail) state_q <= H_PEND;
        end
        H_PEND: begin
          if (pop_ok) begin
            state_q <= ram_avail ? H_PEND : H_EMPTY;
          end else begin
            out_reg_q <= RAM_R_DATA;
            state_q   <= H_HOLD;
          end
        end
        H_HOLD: begin
          if (pop_ok) state_q <= ram_avail ? H_PEND : H_EMPTY;
        end
        default: state_q <= H_EMPTY;
      endcase
    end
  end

`ifdef LSRAM_FIFO_CTRL_STATUS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (WE & full)  overflow_q  <= 1'b1;
      if (RE & empty) underflow_q <= 1'b1;
    end
  end

  assign OVERFLOW  = overflow_q;
  assign UNDERFLOW = underflow_q;
`else
  assign OVERFLOW  = 1'b0;
  assign UNDERFLOW = 1'b0;
`endif

  // In H_PEND the word read last cycle is forwarded straight from the RAM.
  always_comb begin
    case (state_q)
      H_PEND:  DATA_OUT = RAM_R_DATA;
      H_HOLD:  DATA_OUT = out_reg_q;
      default: DATA_OUT = '0;
    endcase
  end

  assign EMPTY      = empty;
  assign FULL       = full;
  assign COUNT      = count_q;
  assign RAM_W_DATA = DATA_IN;
  assign RAM_W_ADDR = wr_ptr_q;
  assign RAM_W_EN   = push_ok;
  assign RAM_R_ADDR = rd_ptr_q;
  assign RAM_R_EN   = rd_issue;

endmodule
